// File: rtl/tpu_host_seq.sv
// Host-side bus sequencer for the matrix accelerator.
// Loads A/B/C-init, triggers matmul, waits, then copies C out.
module tpu_host_seq #(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int MAW      = 16,
  parameter int WAIT_CYC = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear_c,
  input  logic [MAW-1:0]   src_base,
  input  logic [MAW-1:0]   dst_base,
  output logic             busy,
  output logic             done,
  output logic [MAW-1:0]   src_addr,
  input  logic [DATAW-1:0] src_rdata,
  output logic             dst_we,
  output logic [MAW-1:0]   dst_addr,
  output logic [DATAW-1:0] dst_wdata,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int NW   = 4 * DIM;
  localparam int NC   = 2 * DIM;
  localparam int MAXC = (WAIT_CYC > NW + 2) ? WAIT_CYC : NW + 2;
  localparam int CW   = $clog2(MAXC + 1) + 1;
  localparam int IW   = $clog2(NW);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_READ, S_DONE
  } state_t;

  state_t           r_state, w_nstate;
  logic [CW-1:0]    r_cnt, w_ncnt;
  logic             r_clr;
  logic [MAW-1:0]   r_dbase;
  logic [MAW-1:0]   r_src_addr;
  logic             r_p_v, r_w_v;
  logic [IW-1:0]    r_p_idx, r_w_idx;
  logic [DATAW-1:0] r_w_data;
  logic             r_dst_we;
  logic [MAW-1:0]   r_dst_addr;
  logic [DATAW-1:0] r_dst_data;

  logic             w_issue, w_rd;
  logic             w_rw;
  logic [ADDRW-1:0] w_addr, w_ix;
  logic [DATAW-1:0] w_wdata;

  assign w_issue = (r_state == S_LOAD) && (r_cnt < CW'(NW));
  assign w_rd    = (r_state == S_READ) && (r_cnt < CW'(NC));

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_ncnt = '0;
        if (start) w_nstate = S_LOAD;
      end
      S_LOAD: if (r_cnt == CW'(NW + 1)) begin
        w_nstate = S_TRIG;
        w_ncnt   = '0;
      end
      S_TRIG: begin
        w_nstate = S_WAIT;
        w_ncnt   = '0;
      end
      S_WAIT: if (r_cnt == CW'(WAIT_CYC - 1)) begin
        w_nstate = S_READ;
        w_ncnt   = '0;
      end
      S_READ: if (r_cnt == CW'(NC)) begin
        w_nstate = S_DONE;
        w_ncnt   = '0;
      end
      S_DONE: begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  // source word pipeline: addr -> data -> bus write, 2 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr      <= 1'b0;
      r_dbase    <= '0;
      r_src_addr <= '0;
      r_p_v      <= 1'b0;
      r_p_idx    <= '0;
      r_w_v      <= 1'b0;
      r_w_idx    <= '0;
      r_w_data   <= '0;
      r_dst_we   <= 1'b0;
      r_dst_addr <= '0;
      r_dst_data <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (r_state == S_IDLE && start) begin
        r_clr      <= clear_c;
        r_dbase    <= dst_base;
        r_src_addr <= src_base;
      end else if (w_issue && r_cnt != CW'(NW - 1)) begin
        r_src_addr <= r_src_addr + 1'b1;
      end
      r_p_v    <= w_issue;
      r_p_idx  <= r_cnt[IW-1:0];
      r_w_v    <= r_p_v;
      r_w_idx  <= r_p_idx;
      r_w_data <= (r_clr && r_p_idx >= IW'(NC)) ? '0 : src_rdata;
      r_dst_we <= w_rd;
      if (w_rd) begin
        r_dst_addr <= r_dbase + MAW'(r_cnt);
        r_dst_data <= tpu_rdata;
      end
    end
  end

  assign w_ix = ADDRW'(r_w_idx);

  always_comb begin
    w_rw    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (r_w_v) begin
      w_rw    = 1'b1;
      w_wdata = r_w_data;
      if (r_w_idx < IW'(DIM))
        w_addr = ADDRW'(16'h0100) | (w_ix << 3);
      else if (r_w_idx < IW'(NC))
        w_addr = ADDRW'(16'h0200) | ((w_ix - ADDRW'(DIM)) << 3);
      else
        w_addr = ADDRW'(16'h0300) | ((w_ix - ADDRW'(NC)) << 3);
    end else if (r_state == S_TRIG) begin
      w_rw   = 1'b1;
      w_addr = ADDRW'(16'h0400);
    end else if (w_rd) begin
      w_addr = ADDRW'(16'h0300) | (ADDRW'(r_cnt) << 3);
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign src_addr  = r_src_addr;
  assign dst_we    = r_dst_we;
  assign dst_addr  = r_dst_addr;
  assign dst_wdata = r_dst_data;
  assign tpu_r_w   = w_rw;
  assign tpu_addr  = w_addr;
  assign tpu_wdata = w_wdata;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq with a behavioural accelerator
// and source/destination buffers.
module tb_tpu_host_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_c = 1'b0;
  logic [15:0] src_base = '0;
  logic [15:0] dst_base = '0;
  logic        busy, done, dst_we, tpu_r_w;
  logic [15:0] src_addr, dst_addr, tpu_addr;
  logic [63:0] src_rdata, dst_wdata, tpu_wdata, tpu_rdata;

  tpu_host_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_c(clear_c),
    .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done),
    .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr),
    .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] src_mem [0:65535];
  always @(posedge clk) src_rdata <= src_mem[src_addr];

  // accelerator model: C = A*B + C, 8-bit operands, 16-bit lanes
  logic [63:0] ma [8];
  logic [63:0] mb [8];
  logic [63:0] mc [16];
  assign tpu_rdata = (tpu_addr[11:8] == 4'h3) ? mc[tpu_addr[6:3]] : '0;

  always @(posedge clk) begin
    logic [15:0] s;
    logic [63:0] w;
    if (rst_n && tpu_r_w) begin
      case (tpu_addr[11:8])
        4'h1: ma[tpu_addr[5:3]] <= tpu_wdata;
        4'h2: mb[tpu_addr[5:3]] <= tpu_wdata;
        4'h3: mc[tpu_addr[6:3]] <= tpu_wdata;
        4'h4: begin
          for (int c = 0; c < 16; c++) begin
            w = '0;
            for (int l = 0; l < 4; l++) begin
              s = mc[c][16*l +: 16];
              for (int k = 0; k < 8; k++)
                s = s + 16'(ma[c>>1][8*k +: 8]) *
                        16'(mb[k][8*((c&1)*4+l) +: 8]);
              w[16*l +: 16] = s;
            end
            mc[c] <= w;
          end
        end
        default: ;
      endcase
    end
  end

  int t0 = 0;
  int busy_cnt;
  int wr_cyc[$], rd_cyc[$], dw_cyc[$], done_rel[$], done_abs[$];
  logic [15:0] wr_addr[$], rd_addr[$], dw_addr[$];
  logic [63:0] wr_data[$], dw_data[$];
  logic [15:0] srca [0:199];

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (rel >= 0 && rel < 200) srca[rel] = src_addr;
    if (tpu_r_w) begin
      wr_cyc.push_back(rel);
      wr_addr.push_back(tpu_addr);
      wr_data.push_back(tpu_wdata);
    end else if (tpu_addr != 16'h0) begin
      rd_cyc.push_back(rel);
      rd_addr.push_back(tpu_addr);
    end
    if (dst_we) begin
      dw_cyc.push_back(rel);
      dw_addr.push_back(dst_addr);
      dw_data.push_back(dst_wdata);
    end
    if (done) begin
      done_rel.push_back(rel);
      done_abs.push_back(cyc);
    end
    if (busy) busy_cnt++;
  end

  int pass_n = 0;
  int tot_n = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rd_cyc.delete(); rd_addr.delete();
    dw_cyc.delete(); dw_addr.delete(); dw_data.delete();
    done_rel.delete(); done_abs.delete();
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) srca[i] = 'x;
  endtask

  task automatic launch(input bit clr, input logic [15:0] sb,
                        input logic [15:0] db, input bit hold);
    @(posedge clk); #1;
    clear_c = clr; src_base = sb; dst_base = db; start = 1'b1;
    t0 = cyc;
    clear_logs();
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (done_rel.size() == 0 && n < lim) begin
      @(posedge clk); n++;
    end
    chk("done_seen", 128'(done_rel.size() > 0), 128'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_trace(input string tag, input logic [15:0] sb,
                             input bit clr);
    logic [15:0] ea;
    logic [63:0] ed;
    for (int i = 0; i < 33; i++) begin
      if (i < 8)       ea = 16'h0100 + 16'(8*i);
      else if (i < 16) ea = 16'h0200 + 16'(8*(i-8));
      else if (i < 32) ea = 16'h0300 + 16'(8*(i-16));
      else             ea = 16'h0400;
      if (i == 32 || (clr && i >= 16)) ed = '0;
      else ed = src_mem[16'(sb + 16'(i))];
      if (i < wr_cyc.size())
        chk($sformatf("%s_bus%0d", tag, i),
            {32'(wr_cyc[i]), wr_addr[i], wr_data[i]},
            {32'(i + 3), ea, ed});
    end
  endtask

  task automatic check_dst(input string tag, input logic [15:0] db,
                           input logic [63:0] e [16]);
    chk({tag, "_dcnt"}, 128'(dw_cyc.size()), 128'(16));
    for (int c = 0; c < 16; c++)
      if (c < dw_cyc.size())
        chk($sformatf("%s_dst%0d", tag, c),
            {32'(dw_cyc[c]), dw_addr[c], dw_data[c]},
            {32'(61 + c), 16'(db + 16'(c)), e[c]});
    if (done_rel.size() > 0)
      chk({tag, "_donecyc"}, 128'(done_rel[0]), 128'(77));
  endtask

  task automatic fill_ab(input logic [15:0] sb, input bit bzero);
    for (int r = 0; r < 8; r++) begin
      src_mem[16'(sb + 16'(r))] = 64'h1 << (8*r);
      src_mem[16'(sb + 16'(8 + r))] = bzero ? 64'h0 : {8{8'(r + 1)}};
    end
  endtask

  logic [63:0] e1 [16];
  logic [63:0] e2 [16];

  initial begin
    for (int i = 0; i < 65536; i++) src_mem[i] = '0;
    for (int i = 0; i < 8; i++) begin ma[i] = '0; mb[i] = '0; end
    for (int i = 0; i < 16; i++) begin
      mc[i] = '0;
      e1[i] = {4{16'((i >> 1) + 1)}};
      e2[i] = 64'h0001_0001_0001_0001;
    end
    clear_logs();

    #2;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_tpu", {tpu_r_w, tpu_addr, tpu_wdata}, '0);
    chk("rst_src", 128'(src_addr), 128'(0));
    chk("rst_dst", {dst_we, dst_addr, dst_wdata}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // identity x ramp, cleared C-init
    fill_ab(16'h0040, 1'b0);
    for (int c = 0; c < 16; c++)
      src_mem[16'h0050 + 16'(c)] = 64'hDEAD_BEEF_0000_0000 | 64'(c);
    launch(1'b1, 16'h0040, 16'h0080, 1'b0);
    wait_done(200);
    chk("t1_src1", 128'(srca[1]), 128'h0040);
    chk("t1_src32", 128'(srca[32]), 128'h005F);
    chk("t1_wrcnt", 128'(wr_cyc.size()), 128'(33));
    check_trace("t1", 16'h0040, 1'b1);
    chk("t1_rdcnt", 128'(rd_cyc.size()), 128'(16));
    if (rd_cyc.size() > 15) begin
      chk("t1_rd0", {32'(rd_cyc[0]), rd_addr[0]}, {32'(60), 16'h0300});
      chk("t1_rd15", {32'(rd_cyc[15]), rd_addr[15]}, {32'(75), 16'h0378});
    end
    check_dst("t1", 16'h0080, e1);
    chk("t1_busycnt", 128'(busy_cnt), 128'(77));
    chk("t1_donecnt", 128'(done_rel.size()), 128'(1));

    // C-init passthrough with B = 0
    fill_ab(16'h0100, 1'b1);
    for (int c = 0; c < 16; c++)
      src_mem[16'h0110 + 16'(c)] = 64'h0001_0001_0001_0001;
    launch(1'b0, 16'h0100, 16'h0200, 1'b0);
    wait_done(200);
    check_trace("t2", 16'h0100, 1'b0);
    check_dst("t2", 16'h0200, e2);

    // source latency, tagged words
    for (int w = 0; w < 32; w++)
      src_mem[16'h0300 + 16'(w)] = {56'hA5A5_A5A5_A5A5_A5, 8'(w)};
    launch(1'b0, 16'h0300, 16'h0400, 1'b0);
    wait_done(200);
    if (wr_data.size() > 31) begin
      chk("t3_tag0", {32'(wr_cyc[0]), wr_data[0]},
          {32'(3), 64'hA5A5_A5A5_A5A5_A500});
      chk("t3_tag31", {32'(wr_cyc[31]), wr_data[31]},
          {32'(34), 64'hA5A5_A5A5_A5A5_A51F});
    end
    check_trace("t3", 16'h0300, 1'b0);

    // start pulses during a running job
    launch(1'b1, 16'h0040, 16'h0080, 1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);
    repeat (100) @(posedge clk);
    #1;
    chk("t4_donecnt", 128'(done_rel.size()), 128'(1));
    chk("t4_dstcnt", 128'(dw_cyc.size()), 128'(16));
    chk("t4_busycnt", 128'(busy_cnt), 128'(77));

    // async reset in WAIT
    launch(1'b1, 16'h0040, 16'h0080, 1'b0);
    repeat (39) @(posedge clk);
    #2;
    chk("t5_busy_pre", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_tpu", {tpu_r_w, tpu_addr, tpu_wdata}, '0);
    chk("t5_src", 128'(src_addr), 128'(0));
    chk("t5_dst", {dst_we, dst_addr, dst_wdata, done}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t5_nodone", 128'(done_rel.size()), 128'(0));
    chk("t5_nodst", 128'(dw_cyc.size()), 128'(0));
    launch(1'b1, 16'h0040, 16'h0080, 1'b0);
    wait_done(200);
    check_dst("t5b", 16'h0080, e1);

    // start held high, wrapping source base
    for (int w = 0; w < 32; w++)
      src_mem[16'(16'hFFF0 + 16'(w))] = 64'hC0DE_0000_0000_0000 | 64'(w);
    launch(1'b0, 16'hFFF0, 16'h0500, 1'b1);
    begin
      int n;
      n = 0;
      while (done_abs.size() < 2 && n < 400) begin
        @(posedge clk); n++;
      end
      #1 start = 1'b0;
    end
    chk("t6_two", 128'(done_abs.size()), 128'(2));
    if (done_abs.size() > 1) begin
      chk("t6_gap", 128'(done_abs[1] - done_abs[0]), 128'(78));
      chk("t6_done0", 128'(done_rel[0]), 128'(77));
    end
    chk("t6_srcF", 128'(srca[16]), 128'hFFFF);
    chk("t6_wrap", 128'(srca[17]), 128'h0000);
    check_trace("t6", 16'hFFF0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("t6_idle", 128'(busy), 128'(0));
    chk("t6_busycnt", 128'(busy_cnt), 128'(154));

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
